uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

Boot-time program loader between the UART receiver and instruction memory. It consumes the received byte stream and parses a 4-byte little-endian word-count header, then packs the following bytes into 32-bit little-endian words. It writes those words to consecutive memory addresses and returns an acknowledge byte over the UART transmitter. Finally it asserts `done` so the core can be released from reset.

## Interface
Parameters:
- ADDR_W, 15, memory word-address width; capacity MAX_WORDS = 2**ADDR_W
- BASE_ADDR, 0, word address of the first program word
- ACK_BYTE, 8'hAA, byte sent after the last word is written

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- rx_data  in  8  received byte, valid only while rx_valid=1
- rx_valid  in  1  one-cycle pulse per received byte
- rx_ferr  in  1  framing-error level from the receiver
- tx_busy  in  1  transmitter busy; tx_start is ignored by the transmitter while high
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- done  out  1  load complete, sticky
- err  out  1  load aborted, sticky
- err_code  out  2  0 none, 1 framing error, 2 count overflow
- words_loaded  out  ADDR_W+1  words written so far

## Operation
- States: S_HDR, S_BODY, S_ACK, S_DONE, S_ERR. Reset enters S_HDR.
- Byte counter `bidx` is 2 bits. Bytes are shifted into a 32-bit assembly register in little-endian order: byte k lands in bits [8k+7:8k].
- S_HDR: after 4 bytes, N is the assembled value.
  - N > MAX_WORDS -> S_ERR, err_code=2.
  - N == 0 -> S_ACK.
  - Otherwise -> S_BODY, with word index cleared.
- S_BODY: on each 4th byte:
  - issue a write of the assembled word to BASE_ADDR + index;
  - increment index and words_loaded;
  - when index reaches N -> S_ACK.
- Address arithmetic is modulo 2**ADDR_W. BASE_ADDR + N is allowed to wrap; no check is made.
- S_ACK: wait until tx_busy=0. Then drive tx_data=ACK_BYTE and tx_start=1 for exactly one cycle, and go to S_DONE.
- S_DONE: done=1. All rx_valid pulses are ignored. The block stays here until reset.
- Framing error: rx_ferr=1 in any cycle while in S_HDR or S_BODY -> S_ERR, err=1, err_code=1.
  - Any partial word is discarded and no further writes occur.
  - rx_ferr is ignored in S_ACK and S_DONE.
- Simultaneous rx_valid and rx_ferr: the error wins and the byte is dropped.
- S_ERR: err=1 and err_code hold until reset. No writes, no tx_start, done stays 0.
- Reset mid-load:
  - returns to S_HDR;
  - clears bidx, index, words_loaded, done, err and err_code;
  - deasserts mem_we and tx_start in the same edge.
  - Memory contents are not cleared.

## Timing
- Reset values: tx_data=0, tx_start=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, err_code=0, words_loaded=0.
- All outputs are registered.
- Write latency: if the 4th byte of word i arrives as rx_valid in cycle t, then in cycle t+1:
  - mem_we=1, mem_addr=BASE_ADDR+i, mem_wdata=word i;
  - words_loaded shows i+1.
- mem_we is high for exactly one cycle per word. mem_addr and mem_wdata hold their last values afterwards.
- Back-to-back rx_valid on consecutive cycles is accepted at full rate, with no byte loss.
- State update timing:
  - S_HDR -> S_BODY/S_ACK/S_ERR takes effect in cycle t+1 after the 4th header byte in cycle t.
  - The last-word write (cycle t+1) and the entry into S_ACK (cycle t+1) coincide.
- S_ACK timing:
  - tx_start is asserted at the earliest in the cycle after S_ACK entry, and only in a cycle where the sampled tx_busy was 0.
  - done rises the cycle after tx_start.
- Framing error timing: rx_ferr sampled high in cycle t -> err=1 and err_code valid in cycle t+1.

## Test plan
- Header 02 00 00 00, then bytes 11 22 33 44 55 66 77 88, BASE_ADDR=0 -> writes (0, 32'h44332211) and (1, 32'h88776655), each a 1-cycle mem_we. Then one tx_start with tx_data=8'hAA, done=1, words_loaded=2.
- Header 00 00 00 00 -> no mem_we; tx_start once; done=1 the cycle after.
- ADDR_W=4, header 11 00 00 00 (N=17 > 16) -> err=1, err_code=2, no writes, no tx_start.
- rx_ferr pulse after 6 body bytes of N=3 -> exactly 1 write, err_code=1. Later rx_valid bytes produce no writes; done stays 0.
- tx_busy held 1 for 50 cycles on S_ACK entry -> tx_start stays 0, then pulses once in the first cycle after tx_busy falls.
- rstn low for 1 cycle after the 2nd body byte, then a full 1-word load 01 00 00 00 DE AD BE EF -> write (0, 32'hEFBEADDE), words_loaded=1, done=1.

Source files
------------

// File: rtl/uart_prog_loader.sv
// Boot loader: parses a 4-byte LE word-count header, then packs LE bytes into 32-bit words written to memory.
// Acks over UART once all words are written. Errors (framing, oversize count) are sticky until reset.
module uart_prog_loader #(
  parameter int         ADDR_W    = 15,
  parameter int         BASE_ADDR = 0,
  parameter logic [7:0] ACK_BYTE  = 8'hAA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {S_HDR, S_BODY, S_ACK, S_DONE, S_ERR} state_t;

  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [31:0]       word_w;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W-1:0] base_w;

  // The 4th byte completes the word combinationally so the write can be issued on the next edge.
  assign word_w  = {rx_data, asm_q};
  assign idx_inc = idx_q + (ADDR_W+1)'(1);
  assign base_w  = ADDR_W'(BASE_ADDR);

  always_comb begin
    state_d     = state_q;
    bidx_d      = bidx_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;

    case (state_q)
      S_HDR, S_BODY: begin
        if (rx_ferr) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'd1;
        end else if (rx_valid) begin
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0:    asm_d[7:0]   = rx_data;
            2'd1:    asm_d[15:8]  = rx_data;
            2'd2:    asm_d[23:16] = rx_data;
            default: ;
          endcase
          if (bidx_q == 2'd3) begin
            if (state_q == S_HDR) begin
              if ({1'b0, word_w} > MAX_WORDS) begin
                state_d    = S_ERR;
                err_d      = 1'b1;
                err_code_d = 2'd2;
              end else if (word_w == 32'd0) begin
                state_d = S_ACK;
              end else begin
                state_d = S_BODY;
                cnt_d   = word_w[ADDR_W:0];
                idx_d   = '0;
              end
            end else begin
              mem_we_d    = 1'b1;
              mem_addr_d  = base_w + idx_q[ADDR_W-1:0];
              mem_wdata_d = word_w;
              idx_d       = idx_inc;
              if (idx_inc == cnt_q) state_d = S_ACK;
            end
          end
        end
      end
      S_ACK: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = ACK_BYTE;
          state_d    = S_DONE;
        end
      end
      S_DONE:  done_d = 1'b1;
      S_ERR:   ;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_HDR;
      bidx_q      <= '0;
      asm_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      bidx_q      <= bidx_d;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign words_loaded = idx_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader (ADDR_W=4): directed loads from the test plan followed by random loads,
// each checked against a byte-stream model of the expected writes, ack and error outcome.
module tb_uart_prog_loader;

  localparam int AW = 4;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ferr;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  uart_prog_loader #(.ADDR_W(AW), .BASE_ADDR(0), .ACK_BYTE(8'hAA)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .err(err),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  int vectors = 0;
  int miscompares = 0;

  // Observed activity log, owned by the monitor.
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [AW:0]   wl_q[$];
  int            tx_cnt = 0;
  logic [7:0]    tx_last = 8'h00;
  bit            prev_tx = 1'b0;
  bit            done_seen = 1'b0;
  bit            done_after_tx = 1'b0;

  logic [7:0]    body_q[$];

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wl_q.push_back(words_loaded);
    end
    if (tx_start) begin
      tx_cnt++;
      tx_last = tx_data;
    end
    if (!rstn) done_seen = 1'b0;
    else if (done && !done_seen) begin
      done_seen = 1'b1;
      done_after_tx = prev_tx;
    end
    prev_tx = tx_start;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    tx_busy  = 1'b0;
    rstn     = 1'b0;
    tick();
    rstn     = 1'b1;
  endtask

  // Sends header(n) + body_q, optional framing error alongside byte ferr_at, optional busy hold.
  task automatic run_load(input logic [31:0] n, input int ferr_at, input int busy_cyc,
                          input int gap_max, input bit rst_first);
    int           wbase, tbase, exp_w, nn;
    bit           exp_done;
    logic [1:0]   exp_code;
    logic [7:0]   bytes[$];
    logic [31:0]  ew;
    if (rst_first) do_reset();
    wbase = wa_q.size();
    tbase = tx_cnt;
    if (ferr_at >= 0 && ferr_at < 4) begin
      exp_code = 2'd1; exp_w = 0; exp_done = 1'b0;
    end else if (n > 32'(CAP)) begin
      exp_code = 2'd2; exp_w = 0; exp_done = 1'b0;
    end else begin
      nn = int'(n);
      if (nn > 0 && ferr_at >= 0 && ferr_at < 4 + 4*nn) begin
        exp_code = 2'd1; exp_w = (ferr_at - 4) / 4; exp_done = 1'b0;
      end else begin
        exp_code = 2'd0; exp_w = nn; exp_done = 1'b1;
      end
    end
    bytes = {n[7:0], n[15:8], n[23:16], n[31:24]};
    foreach (body_q[i]) bytes.push_back(body_q[i]);
    tx_busy = (busy_cyc > 0);
    for (int p = 0; p < bytes.size(); p++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
      rx_ferr = (p == ferr_at);
      send(bytes[p]);
      rx_ferr = 1'b0;
      if (p >= 4 && (p - 4) % 4 == 3 && (p - 4) / 4 < exp_w) begin
        ew = {bytes[p], bytes[p-1], bytes[p-2], bytes[p-3]};
        check("wr_latency_we", mem_we, 1);
        check("wr_latency_addr", mem_addr, (p - 4) / 4 % CAP);
        check("wr_latency_data", mem_wdata, ew);
      end
    end
    if (busy_cyc > 0) begin
      repeat (busy_cyc) tick();
      check("tx_held_while_busy", tx_cnt - tbase, 0);
      tx_busy = 1'b0;
      if (exp_done) begin
        tick();
        check("tx_start_after_busy", tx_start, 1);
      end
    end
    for (int k = 0; k < 40 && !done; k++) tick();
    repeat (3) tick();
    check("write_count", wa_q.size() - wbase, exp_w);
    for (int i = 0; i < exp_w && wbase + i < wa_q.size(); i++) begin
      ew = {bytes[4+4*i+3], bytes[4+4*i+2], bytes[4+4*i+1], bytes[4+4*i]};
      check("wr_addr", wa_q[wbase+i], i % CAP);
      check("wr_data", wd_q[wbase+i], ew);
      check("wr_words_loaded", wl_q[wbase+i], i + 1);
    end
    check("done", done, exp_done);
    check("err", err, !exp_done);
    check("err_code", err_code, exp_code);
    check("words_loaded", words_loaded, exp_w);
    check("tx_start_count", tx_cnt - tbase, exp_done);
    if (exp_done) begin
      check("tx_data", tx_last, 8'hAA);
      check("done_after_tx", done_after_tx, 1);
    end
  endtask

  initial begin
    logic [31:0] n;
    int          total, ferr_at, busy;
    rstn = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_ferr = 1'b0; tx_busy = 1'b0;
    tick();
    tick();
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", {err, err_code}, 0);
    check("rst_words_loaded", words_loaded, 0);

    // Two-word load, back-to-back bytes.
    body_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(32'd2, -1, 0, 0, 1'b1);
    // Zero-length load; trailing bytes must be ignored.
    body_q = {8'h01, 8'h02, 8'h03, 8'h04};
    run_load(32'd0, -1, 0, 0, 1'b1);
    // Oversized count.
    body_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(32'd17, -1, 0, 0, 1'b1);
    // Framing error alongside the 7th body byte of a 3-word load.
    body_q = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
              8'hA8, 8'hA9, 8'hAB, 8'hAC, 8'hAD, 8'hAE};
    run_load(32'd3, 10, 0, 0, 1'b1);
    // Transmitter busy for 50 cycles at ack time.
    body_q = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    run_load(32'd2, -1, 50, 0, 1'b1);
    // Full capacity.
    body_q.delete();
    repeat (4 * CAP) body_q.push_back(8'($urandom));
    run_load(32'(CAP), -1, 0, 1, 1'b1);

    // Reset after the 2nd body byte, then a fresh 1-word load.
    do_reset();
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'h12); send(8'h34);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("midrst_words_loaded", words_loaded, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_err", err, 0);
    body_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(32'd1, -1, 0, 0, 1'b0);

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 9))
        0:       n = $urandom | 32'h100;
        1:       n = 32'(CAP + 1 + $urandom_range(0, 5));
        default: n = 32'($urandom_range(0, CAP));
      endcase
      body_q.delete();
      if (n <= 32'(CAP)) repeat (4 * int'(n)) body_q.push_back(8'($urandom));
      repeat ($urandom_range(0, 6)) body_q.push_back(8'($urandom));
      total   = 4 + body_q.size();
      ferr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, total - 1)) : -1;
      busy    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      run_load(n, ferr_at, busy, 2, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
